// File: rtl/gticc_pkg.sv
// Shared types and constants for the GT receive comma aligner.
package gticc_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } gticc_align_state_e;

  localparam logic [7:0] K28_5 = 8'hBC;

endpackage

// File: rtl/gticc_comma_find.sv
// Per-byte comma detection with a lowest-index priority encoder.
module gticc_comma_find
  import gticc_pkg::*;
#(
  parameter int         NBYTES = 4,
  parameter logic [7:0] COMMA  = K28_5
) (
  input  logic [8*NBYTES-1:0]       rxdata,
  input  logic [NBYTES-1:0]         rxcharisk,
  output logic                      hit,
  output logic [$clog2(NBYTES)-1:0] pos
);
  localparam int PW = $clog2(NBYTES);

  logic [NBYTES-1:0] hit_vec_s;

  // A byte hits only when it is flagged as a K-character and equals the comma.
  always_comb begin
    hit_vec_s = {NBYTES{1'b0}};
    for (int i = 0; i < NBYTES; i++) begin
      hit_vec_s[i] = rxcharisk[i] && (rxdata[8*i +: 8] == COMMA);
    end
  end

  // Scan downwards so the lowest hitting index is the one that sticks.
  always_comb begin
    hit = |hit_vec_s;
    pos = {PW{1'b0}};
    for (int i = NBYTES - 1; i >= 0; i--) begin
      pos = hit_vec_s[i] ? PW'(i) : pos;
    end
  end

endmodule

// File: rtl/gticc_rx_align.sv
// Fabric comma aligner for one 8b10b GT channel: rotates bytes so the comma
// lands on byte 0, tracks HUNT/VERIFY/LOCKED and counts errored words.
module gticc_rx_align
  import gticc_pkg::*;
#(
  parameter int         NBYTES        = 4,
  parameter logic [7:0] COMMA         = K28_5,
  parameter int         LOCK_CNT      = 4,
  parameter int         LOSS_CNT      = 8,
  parameter int         COMMA_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      gt_ready,
  input  logic [8*NBYTES-1:0]       rxdata,
  input  logic [NBYTES-1:0]         rxcharisk,
  input  logic [NBYTES-1:0]         rxerr,
  input  logic                      clr_err,
  output logic [8*NBYTES-1:0]       data,
  output logic [NBYTES-1:0]         data_k,
  output logic                      data_valid,
  output logic                      locked,
  output logic [$clog2(NBYTES)-1:0] align_pos,
  output logic [15:0]               err_cnt
);
  localparam int W  = 8 * NBYTES;
  localparam int PW = $clog2(NBYTES);
  localparam int TW = $clog2(COMMA_TIMEOUT + 1);

  logic               hit_s;
  logic [PW-1:0]      pos_s;
  logic               err_any_s;
  logic               aligned_hit_s;
  logic               bad_s;
  logic               tmo_hit_s;

  gticc_align_state_e state_q, state_d;
  logic [PW-1:0]      align_pos_q, align_pos_d;
  logic [3:0]         match_cnt_q, match_cnt_d;
  logic [7:0]         bad_cnt_q, bad_cnt_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [15:0]        err_cnt_q, err_cnt_d;

  logic [W-1:0]       prev_data_q;
  logic [NBYTES-1:0]  prev_k_q;
  logic [W-1:0]       rot_data_s;
  logic [NBYTES-1:0]  rot_k_s;
  logic [W-1:0]       data_q;
  logic [NBYTES-1:0]  data_k_q;
  logic               data_valid_q;
  logic               locked_q;

  gticc_comma_find #(
    .NBYTES (NBYTES),
    .COMMA  (COMMA)
  ) u_comma_find (
    .rxdata    (rxdata),
    .rxcharisk (rxcharisk),
    .hit       (hit_s),
    .pos       (pos_s)
  );

  assign err_any_s     = |rxerr;
  assign aligned_hit_s = hit_s && (pos_s == align_pos_q);
  assign bad_s         = err_any_s || (hit_s && !aligned_hit_s);
  assign tmo_hit_s     = (tmo_cnt_q == TW'(COMMA_TIMEOUT - 1));

  // {current, previous} shifted down by align_pos bytes gives prev[p..] then cur[..p-1].
  always_comb begin
    rot_data_s = W'({rxdata, prev_data_q} >> {align_pos_q, 3'b000});
    rot_k_s    = NBYTES'({rxcharisk, prev_k_q} >> align_pos_q);
  end

  // Alignment FSM next-state and counter updates.
  always_comb begin
    state_d     = state_q;
    align_pos_d = align_pos_q;
    match_cnt_d = match_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    if (!gt_ready) begin
      state_d     = HUNT;
      match_cnt_d = 4'd0;
      bad_cnt_d   = 8'd0;
      tmo_cnt_d   = {TW{1'b0}};
    end else begin
      case (state_q)
        HUNT: begin
          if (hit_s || tmo_hit_s) begin
            tmo_cnt_d = {TW{1'b0}};
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
          if (hit_s && !err_any_s) begin
            align_pos_d = pos_s;
            match_cnt_d = 4'd1;
            bad_cnt_d   = 8'd0;
            if (LOCK_CNT == 1) begin
              state_d = LOCKED;
            end else begin
              state_d = VERIFY;
            end
          end else begin
            state_d = HUNT;
          end
        end
        VERIFY: begin
          // Any error outranks a same-cycle aligned comma.
          if (err_any_s || (hit_s && !aligned_hit_s) || (!aligned_hit_s && tmo_hit_s)) begin
            state_d     = HUNT;
            match_cnt_d = 4'd0;
            tmo_cnt_d   = {TW{1'b0}};
          end else if (aligned_hit_s) begin
            tmo_cnt_d = {TW{1'b0}};
            if (match_cnt_q + 4'd1 == 4'(LOCK_CNT)) begin
              state_d     = LOCKED;
              match_cnt_d = 4'd0;
              bad_cnt_d   = 8'd0;
            end else begin
              state_d     = VERIFY;
              match_cnt_d = match_cnt_q + 4'd1;
            end
          end else begin
            state_d   = VERIFY;
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
        end
        LOCKED: begin
          if (aligned_hit_s) begin
            tmo_cnt_d = {TW{1'b0}};
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
          if (bad_s) begin
            bad_cnt_d = bad_cnt_q + 8'd1;
          end else if (aligned_hit_s) begin
            bad_cnt_d = 8'd0;
          end else begin
            bad_cnt_d = bad_cnt_q;
          end
          if ((bad_s && (bad_cnt_q + 8'd1 == 8'(LOSS_CNT))) || (!aligned_hit_s && tmo_hit_s)) begin
            state_d     = HUNT;
            match_cnt_d = 4'd0;
            bad_cnt_d   = 8'd0;
            tmo_cnt_d   = {TW{1'b0}};
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d     = HUNT;
          match_cnt_d = 4'd0;
          bad_cnt_d   = 8'd0;
          tmo_cnt_d   = {TW{1'b0}};
        end
      endcase
    end
  end

  // Errored words while locked, saturating; a clear pulse beats an increment.
  always_comb begin
    if (clr_err) begin
      err_cnt_d = 16'd0;
    end else if (gt_ready && (state_q == LOCKED) && err_any_s && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State, counters, previous word and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      align_pos_q  <= {PW{1'b0}};
      match_cnt_q  <= 4'd0;
      bad_cnt_q    <= 8'd0;
      tmo_cnt_q    <= {TW{1'b0}};
      err_cnt_q    <= 16'd0;
      prev_data_q  <= {W{1'b0}};
      prev_k_q     <= {NBYTES{1'b0}};
      data_q       <= {W{1'b0}};
      data_k_q     <= {NBYTES{1'b0}};
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      align_pos_q  <= align_pos_d;
      match_cnt_q  <= match_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      err_cnt_q    <= err_cnt_d;
      prev_data_q  <= rxdata;
      prev_k_q     <= rxcharisk;
      data_q       <= rot_data_s;
      data_k_q     <= rot_k_s;
      data_valid_q <= (state_q == LOCKED);
      locked_q     <= (state_d == LOCKED);
    end
  end

  assign data       = data_q;
  assign data_k     = data_k_q;
  assign data_valid = data_valid_q;
  assign locked     = locked_q;
  assign align_pos  = align_pos_q;
  assign err_cnt    = err_cnt_q;

endmodule
